// File: rtl/stream_mem_writer_pkg.sv
// Shared definitions for the memory write-side stream block and the memory array.
// The array uses the same default geometry so both sides stay consistent.
package stream_mem_writer_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/stream_mem_writer.sv
// Converts a valid/ready word stream into a registered synchronous memory write port,
// filling a block of consecutive (wrapping) addresses per start command.
module stream_mem_writer
  import stream_mem_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_WRITE = 2'(WRITE);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_cnt_r;
  logic [ADDR_WIDTH:0]   remaining_r;
  logic                  xfer_s;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;

  // Status decoded straight from the state register so a reset clears them at once.
  assign in_ready = (state_r == ST_WRITE);
  assign busy     = (state_r != ST_IDLE);
  assign done     = (state_r == ST_DONE);
  assign xfer_s   = in_valid && in_ready;

  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;

  // Next-state decode; start only matters in IDLE, and a zero length skips WRITE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (length == REM_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (xfer_s && (remaining_r == REM_ONE)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Address and word counters; the address wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt_r  <= {ADDR_WIDTH{1'b0}};
      remaining_r <= REM_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (length != REM_ZERO)) begin
            addr_cnt_r  <= start_addr;
            remaining_r <= length;
          end
        end
        ST_WRITE: begin
          if (xfer_s) begin
            addr_cnt_r  <= addr_cnt_r + ADDR_ONE;
            remaining_r <= remaining_r - REM_ONE;
          end
        end
        ST_DONE: begin
          addr_cnt_r  <= addr_cnt_r;
          remaining_r <= remaining_r;
        end
        default: begin
          addr_cnt_r  <= {ADDR_WIDTH{1'b0}};
          remaining_r <= REM_ZERO;
        end
      endcase
    end
  end

  // Registered write port: address/data hold their last values between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_en_r <= xfer_s;
      if (xfer_s) begin
        wr_addr_r <= addr_cnt_r;
        wr_data_r <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_stream_mem_writer.sv
// Randomized scoreboard bench for stream_mem_writer driving a sync-write/async-read RAM model.
module tb_stream_mem_writer;
  import stream_mem_writer_pkg::*;

  localparam int AW    = DEFAULT_ADDR_WIDTH;
  localparam int DW    = DEFAULT_DATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, wr_en, busy, done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          ram_clr = 1'b1;
  logic [DW-1:0] ram [DEPTH];
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] shadow [DEPTH];

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  stream_mem_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  // RAM model: synchronous write, asynchronous read; bench-only clear sets a known pattern.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i * 7 + 3);
    end else if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
  end
  assign rd_data = ram[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each cycle either the expected write appears or wr_en must be low.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && !ram_clr) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_en", 32'(wr_en), 32'd1);
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
        shadow[e.a] = e.d;
      end else begin
        chk("idle_wr_en", 32'(wr_en), 32'd0);
      end
    end
  end

  // vmode: 0 valid held high, 1 pattern 1,0,0,1,0,1, 2 random.
  // dmode: 0 dbase+index, 1 random, 2 0x11*(index+1).
  task automatic run_cmd(input logic [AW-1:0] a, input int len, input int vmode,
                         input int dmode, input logic [DW-1:0] dbase,
                         input bit poke_start, input int abort_at);
    int acc = 0;
    int cyc = 0;
    bit v;
    bit [5:0] pat = 6'b101001;
    wr_t e;
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; length = len[AW:0];
    @(posedge clk); #1;
    start = 1'b0;
    if (len == 0) begin
      @(negedge clk);
      chk("zl_done", 32'(done), 32'd1);
      chk("zl_busy", 32'(busy), 32'd1);
      chk("zl_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zl_idle_done", 32'(done), 32'd0);
      chk("zl_idle_busy", 32'(busy), 32'd0);
      return;
    end
    while (acc < len) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = pat[cyc % 6];
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      case (dmode)
        0:       in_data = dbase + DW'(acc);
        1:       in_data = DW'($urandom);
        default: in_data = DW'(8'h11 * (acc + 1));
      endcase
      if (poke_start) begin
        start = 1'b1; start_addr = ~a; length = AW'($urandom_range(1, 20));
      end
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      @(posedge clk);
      if (v) begin
        e.a = a + AW'(acc);
        e.d = in_data;
        exp_q.push_back(e);
        acc++;
      end
      cyc++;
      if (abort_at != 0 && acc == abort_at) begin
        #1;
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        return;
      end
      #1;
      if (cyc > 20 * len + 50) begin
        chk("accept_timeout", 32'(acc), 32'(len));
        break;
      end
    end
    in_valid = 1'b0;
    in_data = DW'($urandom);
    start = poke_start;
    start_addr = ~a;
    length = 9'd1;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("after_done", 32'(done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic sweep();
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      #1;
      chk($sformatf("mem[%0h]", i), 32'(rd_data), 32'(shadow[i]));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = DW'(i * 7 + 3);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    ram_clr = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_cmd(8'h10, 4, 0, 0, 8'hA0, 1'b0, 0);
    run_cmd(8'hFE, 3, 0, 2, 8'h00, 1'b0, 0);
    sweep();
    run_cmd(8'h40, 3, 1, 1, 8'h00, 1'b0, 0);
    run_cmd(8'h55, 0, 0, 1, 8'h00, 1'b0, 0);
    run_cmd(8'h20, 6, 2, 1, 8'h00, 1'b1, 0);
    sweep();
    run_cmd(8'h80, 256, 0, 0, 8'h00, 1'b0, 0);
    sweep();
    run_cmd(8'h30, 8, 0, 1, 8'h00, 1'b0, 3);
    run_cmd(8'h30, 8, 2, 1, 8'h00, 1'b0, 0);
    sweep();
    for (int k = 0; k < 8; k++) begin
      run_cmd(AW'($urandom), $urandom_range(0, 24), 2, 1, 8'h00, 1'($urandom_range(0, 1)), 0);
    end
    sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
